instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 150 +++++++++++++++
 tb/tb_instr_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one memory request per fetch,
// captures the returned word into the instruction register, aborts on timeout.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fetch_start,
  input  logic        i_pc_write,
  input  logic [63:0] i_pc_next,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_data,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  output logic [63:0] o_pc,
  output logic [31:0] o_ir,
  output logic        o_ir_valid,
  output logic        o_fetch_done,
  output logic        o_busy,
  output logic        o_err_timeout,
  output logic        o_err_misaligned
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] ir_q, ir_d;
  logic        irv_q, irv_d;
  logic        done_q, done_d;
  logic        errto_q, errto_d;
  logic        errmis_q, errmis_d;
  logic [63:0] pend_q, pend_d;
  logic        pendv_q, pendv_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [63:0] eff_pc;
  logic [63:0] exit_pc;
  logic        exit_wait;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    req_d     = req_q;
    ir_d      = ir_q;
    irv_d     = irv_q;
    done_d    = 1'b0;
    errto_d   = errto_q;
    errmis_d  = errmis_q;
    pend_d    = pend_q;
    pendv_d   = pendv_q;
    cnt_d     = cnt_q;
    exit_wait = 1'b0;
    eff_pc    = i_pc_write ? i_pc_next : pc_q;
    // A write arriving on the exit cycle itself is the most recent one.
    exit_pc   = i_pc_write ? i_pc_next : (pendv_q ? pend_q : pc_q);

    case (state_q)
      IDLE: begin
        if (i_pc_write) pc_d = i_pc_next;
        if (i_fetch_start) begin
          if (eff_pc[1:0] != 2'b00) begin
            errmis_d = 1'b1;
          end else begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = eff_pc;
            irv_d   = 1'b0;
            cnt_d   = 8'd0;
            pendv_d = 1'b0;
          end
        end
      end
      WAIT: begin
        if (i_pc_write) begin
          pend_d  = i_pc_next;
          pendv_d = 1'b1;
        end
        if (i_imem_ready) begin
          ir_d      = i_imem_data;
          irv_d     = 1'b1;
          done_d    = 1'b1;
          exit_wait = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          errto_d   = 1'b1;
          exit_wait = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (exit_wait) begin
          state_d = IDLE;
          req_d   = 1'b0;
          pc_d    = exit_pc;
          pendv_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous reset has top priority
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      ir_q     <= NOP;
      irv_q    <= 1'b0;
      done_q   <= 1'b0;
      errto_q  <= 1'b0;
      errmis_q <= 1'b0;
      pend_q   <= 64'h0;
      pendv_q  <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      ir_q     <= ir_d;
      irv_q    <= irv_d;
      done_q   <= done_d;
      errto_q  <= errto_d;
      errmis_q <= errmis_d;
      pend_q   <= pend_d;
      pendv_q  <= pendv_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_imem_req       = req_q;
  assign o_imem_addr      = addr_q;
  assign o_pc             = pc_q;
  assign o_ir             = ir_q;
  assign o_ir_valid       = irv_q;
  assign o_fetch_done     = done_q;
  assign o_busy           = (state_q == WAIT);
  assign o_err_timeout    = errto_q;
  assign o_err_misaligned = errmis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: fetch transactions are predicted at issue
// time and checked by an independent monitor when the DUT completes them.
module tb_instr_fetch;

  localparam int unsigned TO  = 16;
  localparam logic [63:0] RPC = 64'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_fetch_start = 1'b0;
  logic        i_pc_write = 1'b0;
  logic [63:0] i_pc_next = 64'h0;
  logic        i_imem_ready = 1'b0;
  logic [31:0] i_imem_data = 32'h0;
  logic        o_imem_req, o_ir_valid, o_fetch_done, o_busy;
  logic        o_err_timeout, o_err_misaligned;
  logic [63:0] o_imem_addr, o_pc;
  logic [31:0] o_ir;

  instr_fetch #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_fetch_start(i_fetch_start),
    .i_pc_write(i_pc_write), .i_pc_next(i_pc_next),
    .i_imem_ready(i_imem_ready), .i_imem_data(i_imem_data),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .o_pc(o_pc),
    .o_ir(o_ir), .o_ir_valid(o_ir_valid), .o_fetch_done(o_fetch_done),
    .o_busy(o_busy), .o_err_timeout(o_err_timeout),
    .o_err_misaligned(o_err_misaligned)
  );

  always #5 clk = ~clk;

  // kind: 0 = captured, 1 = timed out, 2 = aborted by reset
  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [31:0] ir;
    logic        irv;
    logic [63:0] pc;
    logic        errto;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [63:0] m_pc;
  logic [31:0] m_ir;
  logic        m_irv, m_to, m_mis;
  logic        wr_en  [1:TO];
  logic [63:0] wr_val [1:TO];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    i_fetch_start = 1'b0;
    i_pc_write    = 1'b0;
    i_imem_ready  = 1'b0;
  endtask

  function automatic logic [63:0] rnd_pc();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  task automatic clr_wr();
    for (int c = 1; c <= int'(TO); c++) begin
      wr_en[c]  = 1'b0;
      wr_val[c] = 64'h0;
    end
  endtask

  // One fetch: optional write-then-fetch, ready after w wait cycles (w >= TO -> timeout)
  task automatic do_fetch(input logic pcw, input logic [63:0] npc, input int w,
                          input logic [31:0] data, input bit randwr);
    logic [63:0] eff, xpc;
    int   last;
    bit   cap;
    exp_t e;
    eff = pcw ? npc : m_pc;
    if (pcw) m_pc = npc;
    if (randwr) begin
      for (int c = 1; c <= int'(TO); c++) begin
        wr_en[c]  = ($urandom_range(0, 3) == 0);
        wr_val[c] = rnd_pc();
      end
    end
    i_fetch_start = 1'b1;
    i_pc_write    = pcw;
    i_pc_next     = npc;
    if (eff[1:0] != 2'b00) begin
      tick();
      zero_inputs();
      m_mis = 1'b1;
      chk("mis_flag", 64'(o_err_misaligned), 64'd1);
      chk("mis_noreq", 64'(o_imem_req), 64'd0);
      chk("mis_busy", 64'(o_busy), 64'd0);
      chk("mis_ir", 64'(o_ir), 64'(m_ir));
      chk("mis_irv", 64'(o_ir_valid), 64'(m_irv));
      chk("mis_pc", o_pc, m_pc);
      return;
    end
    cap  = (w < int'(TO));
    last = cap ? w + 1 : int'(TO);
    xpc  = m_pc;
    for (int c = 1; c <= last; c++) if (wr_en[c]) xpc = wr_val[c];
    e.addr = eff;
    e.pc   = xpc;
    if (cap) begin
      e.kind = 0; e.ir = data; e.irv = 1'b1; e.lat = w + 2;
    end else begin
      e.kind = 1; e.ir = m_ir; e.irv = 1'b0; e.lat = int'(TO);
      m_to = 1'b1;
    end
    e.errto = m_to;
    m_pc = xpc; m_ir = e.ir; m_irv = e.irv;
    sbq.push_back(e);
    tick();
    for (int c = 1; c <= last; c++) begin
      i_fetch_start = 1'($urandom_range(0, 1));
      i_pc_write    = wr_en[c];
      i_pc_next     = wr_en[c] ? wr_val[c] : {$urandom, $urandom};
      i_imem_ready  = cap && (c == last);
      i_imem_data   = (cap && (c == last)) ? data : $urandom;
      tick();
    end
    zero_inputs();
    i_imem_ready = 1'($urandom_range(0, 1));
    i_imem_data  = $urandom;
    tick();
    zero_inputs();
  endtask

  // Reset on the second WAIT cycle, stray ready right after it
  task automatic do_abort(input logic [31:0] data);
    exp_t e;
    i_fetch_start = 1'b1;
    i_pc_write    = 1'b1;
    i_pc_next     = 64'h40;
    e.kind = 2; e.addr = 64'h40; e.ir = NOP; e.irv = 1'b0;
    e.pc = RPC; e.errto = 1'b0; e.lat = 0;
    sbq.push_back(e);
    tick();
    zero_inputs();
    tick();
    i_reset = 1'b1;
    tick();
    i_reset      = 1'b0;
    i_imem_ready = 1'b1;
    i_imem_data  = data;
    tick();
    zero_inputs();
    m_pc = RPC; m_ir = NOP; m_irv = 1'b0; m_to = 1'b0; m_mis = 1'b0;
    chk("abort_done", 64'(o_fetch_done), 64'd0);
    chk("abort_ir", 64'(o_ir), 64'(NOP));
    chk("abort_irv", 64'(o_ir_valid), 64'd0);
    chk("abort_pc", o_pc, RPC);
    chk("abort_mis", 64'(o_err_misaligned), 64'd0);
    tick();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops a prediction whenever a request completes, times out or is aborted
  initial begin
    int          start_cyc;
    int          req_len;
    logic        in_req;
    logic [63:0] req_addr, req_pc;
    exp_t        e;
    start_cyc = 0; req_len = 0; in_req = 1'b0; req_addr = '0; req_pc = '0;
    forever begin
      @(negedge clk);
      if (i_reset !== 1'b1 && i_fetch_start === 1'b1 && o_busy === 1'b0) start_cyc = cyc;
      if (o_imem_req === 1'b1) begin
        if (!in_req) begin
          in_req = 1'b1; req_addr = o_imem_addr; req_pc = o_pc; req_len = 1;
        end else begin
          req_len++;
          chk("addr_hold", o_imem_addr, req_addr);
          chk("pc_hold", o_pc, req_pc);
        end
        chk("busy_in_wait", 64'(o_busy), 64'd1);
      end
      if (o_fetch_done === 1'b1 || (in_req && o_imem_req !== 1'b1)) begin
        in_req = 1'b0;
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: done=%0b with no fetch outstanding (cycle %0d)",
                   o_fetch_done, cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_vs_kind", 64'(o_fetch_done), 64'(e.kind == 0));
          chk("req_addr", req_addr, e.addr);
          chk("ir", 64'(o_ir), 64'(e.ir));
          chk("ir_valid", 64'(o_ir_valid), 64'(e.irv));
          chk("pc_after", o_pc, e.pc);
          chk("err_timeout", 64'(o_err_timeout), 64'(e.errto));
          if (e.kind == 0) chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
          if (e.kind == 1) chk("wait_len", 64'(req_len), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    logic pcw;
    clr_wr();
    m_pc = RPC; m_ir = NOP; m_irv = 1'b0; m_to = 1'b0; m_mis = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    chk("rst_pc", o_pc, RPC);
    chk("rst_addr", o_imem_addr, RPC);
    chk("rst_ir", 64'(o_ir), 64'(NOP));
    chk("rst_irv", 64'(o_ir_valid), 64'd0);
    chk("rst_req", 64'(o_imem_req), 64'd0);
    chk("rst_done", 64'(o_fetch_done), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_errs", {62'd0, o_err_timeout, o_err_misaligned}, 64'd0);

    do_fetch(1'b0, 64'h0, 3, 32'hFFF0_0093, 1'b0);
    do_fetch(1'b1, 64'h100, 1, $urandom, 1'b0);
    wr_en[1] = 1'b1; wr_val[1] = 64'h104;
    wr_en[2] = 1'b1; wr_val[2] = 64'h200;
    do_fetch(1'b0, 64'h0, 3, $urandom, 1'b0);
    clr_wr();
    do_fetch(1'b0, 64'h0, int'(TO), $urandom, 1'b0);
    do_fetch(1'b0, 64'h0, int'(TO) - 1, $urandom, 1'b0);
    do_fetch(1'b1, 64'h102, 0, $urandom, 1'b0);
    do_abort(32'hDEAD_BEEF);

    for (int n = 0; n < 60; n++) begin
      pcw = (m_pc[1:0] != 2'b00) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      do_fetch(pcw, rnd_pc(), int'($urandom_range(0, TO)), $urandom, 1'b1);
    end

    tick();
    tick();
    chk("queue_drained", 64'(sbq.size()), 64'd0);
    chk("final_err_timeout", 64'(o_err_timeout), 64'(m_to));
    chk("final_err_mis", 64'(o_err_misaligned), 64'(m_mis));
    chk("final_pc", o_pc, m_pc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
